// File: rtl/cache_lru_fill_arbiter_pkg.sv
// Shared types for the cache_lru fill arbiter.
package cache_lru_fill_arbiter_pkg;

  // Wide enough for the largest supported requester count (16).
  typedef logic [3:0] requester_id_t;

endpackage

// File: rtl/cache_lru_fill_arbiter_if.sv
// Requester, cache_lru and hit-path signals of the fill arbiter.
interface cache_lru_fill_arbiter_if #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned NUM_SETS       = 64,
  parameter int unsigned NUM_WAYS       = 4
);
  localparam int unsigned SIW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int unsigned WIW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned IDW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [NUM_REQUESTERS-1:0]     fill_req;
  logic [NUM_REQUESTERS*SIW-1:0] fill_req_set;
  logic [NUM_REQUESTERS-1:0]     fill_busy;
  logic                          fill_hold;
  logic                          resp_valid;
  logic [IDW-1:0]                resp_id;
  logic [WIW-1:0]                resp_way;
  logic                          lru_fill_en;
  logic [SIW-1:0]                lru_fill_set;
  logic [WIW-1:0]                lru_fill_way;
  logic                          access_en;
  logic [SIW-1:0]                access_set;
  logic                          update_en;
  logic [WIW-1:0]                update_way;
  logic                          lru_access_en;
  logic [SIW-1:0]                lru_access_set;
  logic                          lru_update_en;
  logic [WIW-1:0]                lru_update_way;

  modport master (
    output fill_req, fill_req_set, fill_hold, lru_fill_way,
    output access_en, access_set, update_en, update_way,
    input  fill_busy, resp_valid, resp_id, resp_way, lru_fill_en, lru_fill_set,
    input  lru_access_en, lru_access_set, lru_update_en, lru_update_way
  );

  modport slave (
    input  fill_req, fill_req_set, fill_hold, lru_fill_way,
    input  access_en, access_set, update_en, update_way,
    output fill_busy, resp_valid, resp_id, resp_way, lru_fill_en, lru_fill_set,
    output lru_access_en, lru_access_set, lru_update_en, lru_update_way
  );

endinterface

// File: rtl/cache_lru_fill_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at a rotating priority pointer.
module cache_lru_fill_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] i_req,
  input  logic                      i_update,
  output logic [NUM_REQUESTERS-1:0] o_grant_oh_c
);
  localparam int unsigned IDW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int unsigned PW  = IDW + 1;
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQUESTERS - 1);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_grant_idx;
  logic [PW-1:0]  w_idx;
  logic           w_found;

  // Scan from the pointer, wrapping modulo NUM_REQUESTERS; first request wins.
  always_comb begin
    o_grant_oh_c = '0;
    w_grant_idx  = '0;
    w_idx        = '0;
    w_found      = 1'b0;
    for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
      w_idx = PW'(r_ptr) + PW'(k);
      if (w_idx >= PW'(NUM_REQUESTERS)) begin
        w_idx = w_idx - PW'(NUM_REQUESTERS);
      end
      if (!w_found && i_req[w_idx[IDW-1:0]]) begin
        w_found                       = 1'b1;
        w_grant_idx                   = w_idx[IDW-1:0];
        o_grant_oh_c[w_idx[IDW-1:0]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + IDW'(1);
    end
  end

endmodule

// File: rtl/cache_lru_fill_arbiter.sv
// Shares the cache_lru fill port among several miss sources; the hit-path
// access/update signals pass straight through.
module cache_lru_fill_arbiter
  import cache_lru_fill_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned NUM_SETS       = 64,
  parameter int unsigned NUM_WAYS       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  cache_lru_fill_arbiter_if.slave bus
);
  localparam int unsigned SIW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int unsigned WIW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned IDW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [NUM_REQUESTERS-1:0] r_pending;
  logic [SIW-1:0]            r_pending_set [NUM_REQUESTERS];
  logic                      r_in_flight;
  requester_id_t             r_in_flight_id;

  logic [NUM_REQUESTERS-1:0] w_arb_req;
  logic [NUM_REQUESTERS-1:0] w_grant_oh;
  logic [NUM_REQUESTERS-1:0] w_busy;
  logic                      w_grant_any;
  logic [SIW-1:0]            w_fill_set;
  requester_id_t             w_grant_id;
  logic [WIW-1:0]            w_fill_way;

  assign w_arb_req   = bus.fill_hold ? '0 : r_pending;
  assign w_grant_any = |w_grant_oh;

  cache_lru_fill_arbiter_rr_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .i_req       (w_arb_req),
    .i_update    (w_grant_any),
    .o_grant_oh_c(w_grant_oh)
  );

  // Decode the one-hot grant into the granted set and requester id.
  always_comb begin
    w_fill_set = '0;
    w_grant_id = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (w_grant_oh[i]) begin
        w_fill_set = w_fill_set | r_pending_set[i];
        w_grant_id = requester_id_t'(i);
      end
    end
  end

  // Busy covers the pending slot and the response cycle of its fill.
  always_comb begin
    w_busy = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      w_busy[i] = r_pending[i] | (r_in_flight & (r_in_flight_id == requester_id_t'(i)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
        r_pending_set[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
        if (w_grant_oh[i]) begin
          r_pending[i] <= 1'b0;
        end
        if (bus.fill_req[i] && !w_busy[i]) begin
          r_pending[i]     <= 1'b1;
          r_pending_set[i] <= bus.fill_req_set[i*SIW +: SIW];
        end
      end
    end
  end

  // cache_lru returns the victim one cycle after fill_en, so in-flight doubles as resp_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_flight    <= 1'b0;
      r_in_flight_id <= '0;
    end else begin
      r_in_flight <= w_grant_any;
      if (w_grant_any) begin
        r_in_flight_id <= w_grant_id;
      end
    end
  end

  assign w_fill_way         = bus.lru_fill_way;
  assign bus.fill_busy      = w_busy;
  assign bus.resp_valid     = r_in_flight;
  assign bus.resp_id        = IDW'(r_in_flight_id);
  assign bus.resp_way       = w_fill_way;
  assign bus.lru_fill_en    = w_grant_any;
  assign bus.lru_fill_set   = w_fill_set;
  assign bus.lru_access_en  = bus.access_en;
  assign bus.lru_access_set = bus.access_set;
  assign bus.lru_update_en  = bus.update_en;
  assign bus.lru_update_way = bus.update_way;

`ifndef SYNTHESIS
  a_no_req_while_busy: assert property (@(posedge clk) disable iff (reset)
    (bus.fill_req & w_busy) == '0);
  a_update_after_access: assert property (@(posedge clk) disable iff (reset)
    bus.update_en |-> $past(bus.access_en));
`endif

endmodule

// File: tb/tb_cache_lru_fill_arbiter.sv
// Directed bench for cache_lru_fill_arbiter with a small 4-way tree-PLRU fill model.
module tb_cache_lru_fill_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned NS = 64;
  localparam int unsigned NW = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cache_lru_fill_arbiter_if #(.NUM_REQUESTERS(NR), .NUM_SETS(NS), .NUM_WAYS(NW)) bus ();

  cache_lru_fill_arbiter #(.NUM_REQUESTERS(NR), .NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // cache_lru stand-in: victim registered one cycle after fill_en, state updated on fill.
  logic [2:0] plru [NS] = '{default: 3'b000};
  logic [1:0] model_way = 2'd0;

  function automatic logic [1:0] plru_victim(input logic [2:0] s);
    if (!s[0]) return s[1] ? 2'd1 : 2'd0;
    return s[2] ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] s, input logic [1:0] w);
    logic [2:0] n;
    n = s;
    if (w < 2'd2) begin
      n[0] = 1'b1;
      n[1] = (w == 2'd0);
    end else begin
      n[0] = 1'b0;
      n[2] = (w == 2'd2);
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (bus.lru_fill_en) begin
      model_way             <= plru_victim(plru[bus.lru_fill_set]);
      plru[bus.lru_fill_set] <= plru_touch(plru[bus.lru_fill_set], plru_victim(plru[bus.lru_fill_set]));
    end
  end

  assign bus.lru_fill_way = model_way;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] req, input logic [23:0] sets);
    bus.fill_req     = req;
    bus.fill_req_set = sets;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    drive_req(4'b0, 24'd0);
    bus.fill_hold  = 1'b0;
    bus.access_en  = 1'b0;
    bus.access_set = '0;
    bus.update_en  = 1'b0;
    bus.update_way = '0;
    step();
    step();
    #1;
    checks++; if (bus.fill_busy !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b want 0000", bus.fill_busy); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    checks++; if (bus.lru_fill_en !== 1'b0) begin errors++; $display("FAIL reset_fill_en: got %b want 0", bus.lru_fill_en); end
    checks++; if (bus.lru_fill_set !== 6'd0) begin errors++; $display("FAIL reset_fill_set: got %0d want 0", bus.lru_fill_set); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_contention();
    drive_req(4'b1011, {6'd13, 6'd0, 6'd11, 6'd10});
    step();
    drive_req(4'b0, 24'd0);
    #1;
    checks++; if (bus.lru_fill_en !== 1'b1 || bus.lru_fill_set !== 6'd10) begin errors++; $display("FAIL cont_grant0: en %b set %0d want 1/10", bus.lru_fill_en, bus.lru_fill_set); end
    checks++; if (bus.fill_busy !== 4'b1011) begin errors++; $display("FAIL cont_busy_t1: got %b want 1011", bus.fill_busy); end
    step(); #1;
    checks++; if (bus.lru_fill_en !== 1'b1 || bus.lru_fill_set !== 6'd11) begin errors++; $display("FAIL cont_grant1: en %b set %0d want 1/11", bus.lru_fill_en, bus.lru_fill_set); end
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_way !== 2'd0) begin errors++; $display("FAIL cont_resp0: v %b id %0d way %0d want 1/0/0", bus.resp_valid, bus.resp_id, bus.resp_way); end
    checks++; if (bus.fill_busy !== 4'b1011) begin errors++; $display("FAIL cont_busy_t2: got %b want 1011", bus.fill_busy); end
    step(); #1;
    checks++; if (bus.lru_fill_en !== 1'b1 || bus.lru_fill_set !== 6'd13) begin errors++; $display("FAIL cont_grant3: en %b set %0d want 1/13", bus.lru_fill_en, bus.lru_fill_set); end
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_way !== 2'd0) begin errors++; $display("FAIL cont_resp1: v %b id %0d way %0d want 1/1/0", bus.resp_valid, bus.resp_id, bus.resp_way); end
    checks++; if (bus.fill_busy !== 4'b1010) begin errors++; $display("FAIL cont_busy_t3: got %b want 1010", bus.fill_busy); end
    step(); #1;
    checks++; if (bus.lru_fill_en !== 1'b0) begin errors++; $display("FAIL cont_idle: en %b want 0", bus.lru_fill_en); end
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd3) begin errors++; $display("FAIL cont_resp3: v %b id %0d want 1/3", bus.resp_valid, bus.resp_id); end
    checks++; if (bus.fill_busy !== 4'b1000) begin errors++; $display("FAIL cont_busy_t4: got %b want 1000", bus.fill_busy); end
    step(); #1;
    checks++; if (bus.fill_busy !== 4'b0000 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL cont_drain: busy %b v %b want 0000/0", bus.fill_busy, bus.resp_valid); end
    // Pointer wrapped back to 0: requester 0 must beat requester 3.
    drive_req(4'b1001, {6'd23, 6'd0, 6'd0, 6'd20});
    step();
    drive_req(4'b0, 24'd0);
    #1;
    checks++; if (bus.lru_fill_set !== 6'd20) begin errors++; $display("FAIL cont_ptr_wrap: set %0d want 20", bus.lru_fill_set); end
    step(); #1;
    checks++; if (bus.lru_fill_set !== 6'd23) begin errors++; $display("FAIL cont_ptr_next: set %0d want 23", bus.lru_fill_set); end
    step(); step();
  endtask

  task automatic test_single();
    drive_req(4'b0100, {6'd0, 6'd5, 6'd0, 6'd0});
    #1;
    checks++; if (bus.lru_fill_en !== 1'b0) begin errors++; $display("FAIL single_t0_en: got %b want 0", bus.lru_fill_en); end
    step();
    drive_req(4'b0, 24'd0);
    #1;
    checks++; if (bus.lru_fill_en !== 1'b1 || bus.lru_fill_set !== 6'd5) begin errors++; $display("FAIL single_t1: en %b set %0d want 1/5", bus.lru_fill_en, bus.lru_fill_set); end
    checks++; if (bus.fill_busy !== 4'b0100 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_t1_busy: busy %b v %b want 0100/0", bus.fill_busy, bus.resp_valid); end
    step(); #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2 || bus.resp_way !== 2'd0) begin errors++; $display("FAIL single_t2_resp: v %b id %0d way %0d want 1/2/0", bus.resp_valid, bus.resp_id, bus.resp_way); end
    checks++; if (bus.fill_busy !== 4'b0100 || bus.lru_fill_en !== 1'b0) begin errors++; $display("FAIL single_t2_busy: busy %b en %b want 0100/0", bus.fill_busy, bus.lru_fill_en); end
    step(); #1;
    checks++; if (bus.fill_busy !== 4'b0000 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_t3: busy %b v %b want 0000/0", bus.fill_busy, bus.resp_valid); end
    step();
  endtask

  task automatic test_fairness();
    int         exp_id = 0;
    int         grants = 0;
    logic [3:0] req;
    for (int c = 0; c < 24; c++) begin
      req = 4'b0;
      if (c < 20) begin
        req[0] = !bus.fill_busy[0];
        req[1] = !bus.fill_busy[1];
      end
      drive_req(req, {6'd0, 6'd0, 6'd31, 6'd30});
      #1;
      if (bus.lru_fill_en) begin
        checks++; if (bus.lru_fill_set !== 6'(30 + exp_id)) begin errors++; $display("FAIL fair_grant_%0d: set %0d want %0d", grants, bus.lru_fill_set, 30 + exp_id); end
        exp_id = 1 - exp_id;
        grants++;
      end
      step();
    end
    drive_req(4'b0, 24'd0);
    checks++; if (grants < 10) begin errors++; $display("FAIL fair_count: got %0d grants want >= 10", grants); end
    checks++; if (bus.fill_busy !== 4'b0000) begin errors++; $display("FAIL fair_drain: busy %b want 0000", bus.fill_busy); end
  endtask

  task automatic test_hold();
    // Requester 3 alone puts the pointer at 0.
    drive_req(4'b1000, {6'd43, 6'd0, 6'd0, 6'd0});
    step();
    drive_req(4'b0, 24'd0);
    #1;
    checks++; if (bus.lru_fill_en !== 1'b1 || bus.lru_fill_set !== 6'd43) begin errors++; $display("FAIL hold_pre_grant: en %b set %0d want 1/43", bus.lru_fill_en, bus.lru_fill_set); end
    step();
    bus.fill_hold = 1'b1;
    drive_req(4'b0110, {6'd0, 6'd42, 6'd41, 6'd0});
    #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd3) begin errors++; $display("FAIL hold_inflight_resp: v %b id %0d want 1/3", bus.resp_valid, bus.resp_id); end
    step();
    drive_req(4'b0, 24'd0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.lru_fill_en !== 1'b0 || bus.fill_busy !== 4'b0110) begin errors++; $display("FAIL hold_cycle_%0d: en %b busy %b want 0/0110", c, bus.lru_fill_en, bus.fill_busy); end
      step();
    end
    bus.fill_hold = 1'b0;
    #1;
    checks++; if (bus.lru_fill_en !== 1'b1 || bus.lru_fill_set !== 6'd41) begin errors++; $display("FAIL hold_release_g1: en %b set %0d want 1/41", bus.lru_fill_en, bus.lru_fill_set); end
    step(); #1;
    checks++; if (bus.lru_fill_en !== 1'b1 || bus.lru_fill_set !== 6'd42) begin errors++; $display("FAIL hold_release_g2: en %b set %0d want 1/42", bus.lru_fill_en, bus.lru_fill_set); end
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1) begin errors++; $display("FAIL hold_release_r1: v %b id %0d want 1/1", bus.resp_valid, bus.resp_id); end
    step(); #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2) begin errors++; $display("FAIL hold_release_r2: v %b id %0d want 1/2", bus.resp_valid, bus.resp_id); end
    step();
  endtask

  task automatic test_same_set();
    drive_req(4'b0011, {6'd0, 6'd0, 6'd9, 6'd9});
    step();
    drive_req(4'b0, 24'd0);
    #1;
    checks++; if (bus.lru_fill_en !== 1'b1 || bus.lru_fill_set !== 6'd9) begin errors++; $display("FAIL same_grant0: en %b set %0d want 1/9", bus.lru_fill_en, bus.lru_fill_set); end
    step(); #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_way !== 2'd0) begin errors++; $display("FAIL same_resp0: v %b id %0d way %0d want 1/0/0", bus.resp_valid, bus.resp_id, bus.resp_way); end
    checks++; if (bus.lru_fill_en !== 1'b1 || bus.lru_fill_set !== 6'd9) begin errors++; $display("FAIL same_grant1: en %b set %0d want 1/9", bus.lru_fill_en, bus.lru_fill_set); end
    step(); #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_way !== 2'd2) begin errors++; $display("FAIL same_resp1: v %b id %0d way %0d want 1/1/2", bus.resp_valid, bus.resp_id, bus.resp_way); end
    step();
  endtask

  task automatic test_passthrough();
    bus.access_en  = 1'b1;
    bus.access_set = 6'd17;
    #1;
    checks++; if (bus.lru_access_en !== 1'b1 || bus.lru_access_set !== 6'd17) begin errors++; $display("FAIL pass_access: en %b set %0d want 1/17", bus.lru_access_en, bus.lru_access_set); end
    checks++; if (bus.lru_update_en !== 1'b0) begin errors++; $display("FAIL pass_no_update: got %b want 0", bus.lru_update_en); end
    step();
    bus.access_en  = 1'b0;
    bus.update_en  = 1'b1;
    bus.update_way = 2'd3;
    #1;
    checks++; if (bus.lru_update_en !== 1'b1 || bus.lru_update_way !== 2'd3) begin errors++; $display("FAIL pass_update: en %b way %0d want 1/3", bus.lru_update_en, bus.lru_update_way); end
    checks++; if (bus.lru_access_en !== 1'b0) begin errors++; $display("FAIL pass_access_off: got %b want 0", bus.lru_access_en); end
    step();
    bus.update_en = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    drive_req(4'b0100, {6'd0, 6'd50, 6'd0, 6'd0});
    step();
    drive_req(4'b0, 24'd0);
    #1;
    checks++; if (bus.lru_fill_en !== 1'b1 || bus.lru_fill_set !== 6'd50) begin errors++; $display("FAIL rst_pre_grant: en %b set %0d want 1/50", bus.lru_fill_en, bus.lru_fill_set); end
    reset = 1'b1;
    #1;
    checks++; if (bus.fill_busy !== 4'b0000 || bus.lru_fill_en !== 1'b0) begin errors++; $display("FAIL rst_async: busy %b en %b want 0000/0", bus.fill_busy, bus.lru_fill_en); end
    step();
    reset = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.fill_busy !== 4'b0000) begin errors++; $display("FAIL rst_no_resp1: v %b busy %b want 0/0000", bus.resp_valid, bus.fill_busy); end
    step(); #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_resp2: v %b want 0", bus.resp_valid); end
    // Pointer back at 0: requester 0 first, then 3.
    drive_req(4'b1001, {6'd53, 6'd0, 6'd0, 6'd51});
    step();
    drive_req(4'b0, 24'd0);
    #1;
    checks++; if (bus.lru_fill_set !== 6'd51) begin errors++; $display("FAIL rst_ptr_first: set %0d want 51", bus.lru_fill_set); end
    step(); #1;
    checks++; if (bus.lru_fill_set !== 6'd53) begin errors++; $display("FAIL rst_ptr_second: set %0d want 53", bus.lru_fill_set); end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_fairness();
    test_hold();
    test_same_set();
    test_passthrough();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
